// File: rtl/posit_add_arbiter.sv
// Round-robin front end for one shared, pipelined posit adder.
// Results come back through a tagged FWFT response FIFO; credits guarantee FIFO space.
module posit_add_arbiter #(
  parameter int N          = 32,
  parameter int NREQ       = 4,
  parameter int TAG_W      = 2,
  parameter int LATENCY    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic [N-1:0]      add_in1,
  output logic [N-1:0]      add_in2,
  output logic              add_start,
  input  logic [N-1:0]      add_result,
  input  logic              add_done,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [N-1:0]      rsp_result,
  output logic              err_sync,
  output logic              busy
);

  localparam int          PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CW     = $clog2(FIFO_DEPTH + 1);
  localparam int          FW     = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam int unsigned NREQ_U = NREQ;
  localparam logic [CW-1:0]    DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [FW-1:0]    FLUSH_C = FW'(LATENCY);
  localparam logic [TAG_W-1:0] LAST_C  = TAG_W'(NREQ - 1);

  typedef enum logic {FLUSH, RUN} state_t;

  state_t           state, state_nxt;
  logic [FW-1:0]    flush_cnt, flush_cnt_nxt;
  logic [TAG_W-1:0] rr_ptr, rr_nxt;
  logic [TAG_W-1:0] winner, cand;
  logic             grant;
  logic [CW-1:0]    count;

  logic             start_q;
  logic [TAG_W-1:0] tag_q;
  logic             pipe_v   [LATENCY];
  logic [TAG_W-1:0] pipe_tag [LATENCY];

  logic [TAG_W+N-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      occ;
  logic               push, pop;
  logic               err_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state     <= FLUSH;
      flush_cnt <= FLUSH_C;
      rr_ptr    <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      rr_ptr    <= rr_nxt;
    end
  end

  // Winner is the first valid requester at or above rr_ptr, wrapping mod NREQ.
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    grant         = 1'b0;
    winner        = '0;
    cand          = '0;
    req_ready     = '0;
    rr_nxt        = rr_ptr;
    case (state)
      FLUSH: begin
        if (flush_cnt == '0) state_nxt = RUN;
        else                 flush_cnt_nxt = flush_cnt - 1'b1;
      end
      RUN: begin
        if (count < DEPTH_C) begin
          for (int unsigned k = 0; k < NREQ_U; k++) begin
            cand = TAG_W'((32'(rr_ptr) + k) % NREQ_U);
            if (!grant && req_valid[cand]) begin
              grant  = 1'b1;
              winner = cand;
            end
          end
        end
      end
      default: state_nxt = FLUSH;
    endcase
    if (grant) begin
      req_ready = NREQ'(1) << winner;
      rr_nxt    = (winner == LAST_C) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      start_q <= 1'b0;
      tag_q   <= '0;
      add_in1 <= '0;
      add_in2 <= '0;
    end else begin
      start_q <= grant;
      if (grant) begin
        tag_q   <= winner;
        add_in1 <= req_a[winner*N +: N];
        add_in2 <= req_b[winner*N +: N];
      end
    end
  end

  assign add_start = start_q;

  // Tag pipeline mirrors the adder depth so its tail lines up with add_done.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        pipe_v[i]   <= 1'b0;
        pipe_tag[i] <= '0;
      end
    end else begin
      pipe_v[0]   <= start_q;
      pipe_tag[0] <= tag_q;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
    end
  end

  assign push = (state == RUN) && add_done && pipe_v[LATENCY-1];
  assign pop  = rsp_valid && rsp_ready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      err_q <= 1'b0;
    end else if (state == RUN && (add_done != pipe_v[LATENCY-1])) begin
      err_q <= 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {pipe_tag[LATENCY-1], add_result};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      count <= '0;
    end else begin
      case ({grant, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rsp_valid  = (occ != '0);
  assign rsp_tag    = mem[rd_ptr][N +: TAG_W];
  assign rsp_result = mem[rd_ptr][N-1:0];
  assign err_sync   = err_q;
  assign busy       = (count != '0) || (state == FLUSH);

endmodule

// File: tb/tb_posit_add_arbiter.sv
// Randomized bench for posit_add_arbiter: the bench plays the shared adder and
// predicts grants/responses from a queue-based model of the arbitration rules.
module tb_posit_add_arbiter;

  localparam int N = 32, NREQ = 4, TAG_W = 2, LAT = 3, DEPTH = 4;

  logic              aclk = 1'b0;
  logic              areset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a, req_b;
  logic [N-1:0]      add_in1, add_in2, add_result;
  logic              add_start, add_done;
  logic              rsp_valid, rsp_ready;
  logic [TAG_W-1:0]  rsp_tag;
  logic [N-1:0]      rsp_result;
  logic              err_sync, busy;
  logic              inject;

  posit_add_arbiter #(.N(N), .NREQ(NREQ), .TAG_W(TAG_W), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .aclk(aclk), .areset(areset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .add_in1(add_in1), .add_in2(add_in2),
    .add_start(add_start), .add_result(add_result), .add_done(add_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
    .rsp_result(rsp_result), .err_sync(err_sync), .busy(busy)
  );

  always #5 aclk = ~aclk;

  // Stand-in adder: the arbiter is data-agnostic, so only 1+1=2 is a true posit sum.
  function automatic logic [N-1:0] fadd(input logic [N-1:0] a, input logic [N-1:0] b);
    if (a == 32'h4000_0000 && b == 32'h4000_0000) return 32'h4800_0000;
    return a + b + 32'd1;
  endfunction

  // The adder has no reset: it keeps shifting across areset.
  bit         ad_v   [LAT];
  bit [N-1:0] ad_res [LAT];
  always @(posedge aclk) begin
    ad_v[0]   <= add_start;
    ad_res[0] <= fadd(add_in1, add_in2);
    for (int i = 1; i < LAT; i++) begin
      ad_v[i]   <= ad_v[i-1];
      ad_res[i] <= ad_res[i-1];
    end
  end
  assign add_done   = ad_v[LAT-1] | inject;
  assign add_result = ad_res[LAT-1];

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [N-1:0]     res;
    int               vis;
  } exp_t;

  exp_t        q[$];
  int          cyc, flush_edges, rr;
  bit          err_exp, start_prev;
  logic [N-1:0] in1_prev, in2_prev;
  bit          rand_ops;
  int          n_cmp, n_bad;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic step(input logic [NREQ-1:0] v, input bit rdy, input bit inj);
    bit               run, g, pop;
    int               w, idx;
    logic [NREQ-1:0]  exp_ready;
    bit               exp_rv;
    logic [N-1:0]     ga, gb;
    req_valid = v;
    rsp_ready = rdy;
    inject    = inj;
    if (rand_ops)
      for (int i = 0; i < NREQ; i++) begin
        req_a[i*N +: N] = $urandom;
        req_b[i*N +: N] = $urandom;
      end
    #1;
    run = (flush_edges >= LAT + 1);
    g = 0; w = 0;
    if (run && q.size() < DEPTH)
      for (int k = 0; k < NREQ; k++) begin
        idx = (rr + k) % NREQ;
        if (!g && v[idx]) begin g = 1; w = idx; end
      end
    exp_ready = g ? (NREQ'(1) << w) : '0;
    exp_rv    = (q.size() > 0) && (q[0].vis <= cyc);
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    if (exp_rv) begin
      check("rsp_tag", 64'(rsp_tag), 64'(q[0].tag));
      check("rsp_result", 64'(rsp_result), 64'(q[0].res));
    end
    check("busy", 64'(busy), 64'((q.size() != 0) || !run));
    check("err_sync", 64'(err_sync), 64'(err_exp));
    check("add_start", 64'(add_start), 64'(start_prev));
    if (start_prev) begin
      check("add_in1", 64'(add_in1), 64'(in1_prev));
      check("add_in2", 64'(add_in2), 64'(in2_prev));
    end
    pop = exp_rv && rdy;
    ga = req_a[w*N +: N];
    gb = req_b[w*N +: N];
    @(posedge aclk);
    if (pop) void'(q.pop_front());
    if (g) begin
      q.push_back('{tag: TAG_W'(w), res: fadd(ga, gb), vis: cyc + LAT + 2});
      rr = (w + 1) % NREQ;
      in1_prev = ga;
      in2_prev = gb;
    end
    start_prev = g;
    if (inj && run) err_exp = 1;
    flush_edges++;
    cyc++;
    @(negedge aclk);
  endtask

  task automatic do_reset();
    areset = 1'b1;
    q.delete();
    rr = 0; flush_edges = 0; err_exp = 0; start_prev = 0;
    in1_prev = '0; in2_prev = '0;
    req_valid = '0; inject = 0;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_tag", 64'(rsp_tag), 64'd0);
    check("rst_rsp_result", 64'(rsp_result), 64'd0);
    check("rst_add_start", 64'(add_start), 64'd0);
    check("rst_add_in", 64'({add_in1, add_in2}), 64'd0);
    check("rst_err_sync", 64'(err_sync), 64'd0);
    check("rst_busy", 64'(busy), 64'd1);
    @(posedge aclk);
    @(negedge aclk);
    areset = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; rand_ops = 1;
    areset = 1'b1; req_valid = '0; rsp_ready = 1'b0; inject = 0;
    req_a = '0; req_b = '0;
    repeat (2) @(negedge aclk);
    do_reset();

    // Single request from requester 2: 1.0 + 1.0
    repeat (LAT + 2) step('0, 1, 0);
    rand_ops = 0;
    req_a = '0; req_b = '0;
    req_a[2*N +: N] = 32'h4000_0000;
    req_b[2*N +: N] = 32'h4000_0000;
    step(4'b0100, 1, 0);
    repeat (8) step('0, 1, 0);
    rand_ops = 1;

    // Round robin from reset exit
    do_reset();
    repeat (24) step(4'b1111, 1, 0);

    // Back-pressure, single pop, then drain
    repeat (14) step(4'b1111, 0, 0);
    step(4'b1111, 1, 0);
    repeat (6) step(4'b1111, 0, 0);
    repeat (12) step('0, 1, 0);

    // Reset mid-operation: stale adder done pulses must be ignored
    repeat (3) step(4'b1111, 1, 0);
    do_reset();
    repeat (10) step('0, 1, 0);
    do_reset();
    repeat (8) step(4'b1111, 1, 0);

    // Spurious done with an empty pipeline
    repeat (LAT + 6) step('0, 1, 0);
    step('0, 1, 1);
    repeat (20) step(4'($urandom), 1'($urandom), 0);
    do_reset();

    // Full FIFO with simultaneous push/pop
    repeat (LAT + 1) step('0, 0, 0);
    repeat (12) step(4'b1111, 0, 0);
    repeat (30) step(4'b1111, 1, 0);

    // Random traffic
    do_reset();
    repeat (400) step(4'($urandom), ($urandom_range(0, 3) != 0), 0);
    repeat (15) step('0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
